// File: rtl/pwm_sweep_master_if.sv
// Avalon-MM bus bundle between the PWM sweep master and the PWM LED peripheral.
interface pwm_sweep_master_if #(
    parameter int unsigned ADDR_W = 8
);
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/pwm_sweep_master.sv
// Avalon-MM initiator: programs the PWM peripheral, ramps duty 0..duty_max with
// readback verification of each step, then disables the peripheral.
module pwm_sweep_master #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [31:0]         period_val,
    input  logic [7:0]          led_mask,
    input  logic [31:0]         duty_max,
    input  logic [31:0]         step_interval,
    pwm_sweep_master_if.master  bus,
    output logic                busy,
    output logic [31:0]         cur_duty,
    output logic                mismatch
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LAT_W  = 3;

    localparam logic [ADDR_W-1:0] A_EN     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_DUTY   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_LED    = ADDR_W'(3);

    typedef enum logic [3:0] {
        IDLE, WR_PERIOD, WR_LED, WR_DUTY, WR_EN, RD_DUTY, RD_WAIT, HOLD, WR_DIS
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_address, w_addr_nxt;
    logic                r_read, w_read_nxt;
    logic                r_write, w_write_nxt;
    logic [DATA_W-1:0]   r_writedata, w_wdata_nxt;
    logic                r_busy;
    logic [DATA_W-1:0]   r_cur_duty;
    logic                r_mismatch;
    logic [DATA_W-1:0]   r_duty, w_duty_nxt;
    logic [DATA_W-1:0]   r_period, r_duty_max, r_interval;
    logic [7:0]          r_mask;
    logic [DATA_W-1:0]   r_hold_cnt, w_hold_nxt;
    logic [LAT_W-1:0]    r_lat_cnt, w_lat_nxt;
    logic                r_stop;
    logic                w_accept;
    logic                w_stop_req;
    logic                w_sample;

    assign w_accept   = (r_read | r_write) & ~bus.waitrequest;
    assign w_stop_req = r_stop | stop;

    assign bus.address   = r_address;
    assign bus.read      = r_read;
    assign bus.write     = r_write;
    assign bus.writedata = r_writedata;
    assign busy          = r_busy;
    assign cur_duty      = r_cur_duty;
    assign mismatch      = r_mismatch;

    // Next-state and next-command decode; commands are a function of the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_hold_nxt  = r_hold_cnt;
        w_lat_nxt   = r_lat_cnt;
        w_sample    = 1'b0;
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        w_addr_nxt  = r_address;
        w_wdata_nxt = r_writedata;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = WR_PERIOD;
                    w_duty_nxt  = '0;
                end
            end
            WR_PERIOD: if (w_accept) w_state_nxt = w_stop_req ? WR_DIS : WR_LED;
            WR_LED:    if (w_accept) w_state_nxt = w_stop_req ? WR_DIS : WR_DUTY;
            WR_DUTY: begin
                // Enable is written only once, right after the initial zero duty.
                if (w_accept)
                    w_state_nxt = w_stop_req ? WR_DIS : ((r_duty == '0) ? WR_EN : RD_DUTY);
            end
            WR_EN: if (w_accept) w_state_nxt = w_stop_req ? WR_DIS : RD_DUTY;
            RD_DUTY: begin
                if (w_accept) begin
                    w_state_nxt = RD_WAIT;
                    w_lat_nxt   = LAT_W'(READ_LATENCY - 1);
                end
            end
            RD_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_sample    = 1'b1;
                    w_state_nxt = w_stop_req ? WR_DIS : HOLD;
                    w_hold_nxt  = (r_interval == '0) ? '0 : r_interval - 32'd1;
                end else begin
                    w_lat_nxt = r_lat_cnt - LAT_W'(1);
                end
            end
            HOLD: begin
                if (w_stop_req) begin
                    w_state_nxt = WR_DIS;
                end else if (r_hold_cnt == '0) begin
                    if (r_duty < r_duty_max) begin
                        w_duty_nxt  = r_duty + 32'd1;
                        w_state_nxt = WR_DUTY;
                    end else begin
                        w_state_nxt = WR_DIS;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt - 32'd1;
                end
            end
            WR_DIS:  if (w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            WR_PERIOD: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = A_PERIOD;
                w_wdata_nxt = (r_state == IDLE) ? period_val : r_period;
            end
            WR_LED: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = A_LED;
                w_wdata_nxt = DATA_W'(r_mask);
            end
            WR_DUTY: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = A_DUTY;
                w_wdata_nxt = w_duty_nxt;
            end
            WR_EN: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = A_EN;
                w_wdata_nxt = 32'd1;
            end
            RD_DUTY: begin
                w_read_nxt = 1'b1;
                w_addr_nxt = A_DUTY;
            end
            WR_DIS: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = A_EN;
                w_wdata_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_address   <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_writedata <= '0;
            r_busy      <= 1'b0;
            r_cur_duty  <= '0;
            r_mismatch  <= 1'b0;
            r_duty      <= '0;
            r_period    <= '0;
            r_mask      <= '0;
            r_duty_max  <= '0;
            r_interval  <= '0;
            r_hold_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_stop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_address   <= w_addr_nxt;
            r_read      <= w_read_nxt;
            r_write     <= w_write_nxt;
            r_writedata <= w_wdata_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_duty      <= w_duty_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_lat_cnt   <= w_lat_nxt;

            if (r_state == IDLE && start) begin
                r_period   <= period_val;
                r_mask     <= led_mask;
                r_duty_max <= duty_max;
                r_interval <= step_interval;
                r_mismatch <= 1'b0;
            end else if (w_sample && (bus.readdata != r_cur_duty)) begin
                r_mismatch <= 1'b1;
            end

            if (r_state == WR_DUTY && w_accept)
                r_cur_duty <= r_duty;

            // Stop is held until it can take effect at a state boundary.
            if (w_state_nxt == WR_DIS || w_state_nxt == IDLE)
                r_stop <= 1'b0;
            else if (stop && r_state != IDLE && r_state != WR_DIS)
                r_stop <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pwm_sweep_master.sv
// Self-checking bench for pwm_sweep_master: Avalon slave model plus a
// transaction-list reference model of the sweep.
`timescale 1ns/1ps
module tb_pwm_sweep_master;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned RL      = 3;
    localparam int unsigned MAX_CYC = 3000;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [31:0] period_val = '0;
    logic [7:0]  led_mask = '0;
    logic [31:0] duty_max = '0;
    logic [31:0] step_interval = '0;
    logic        busy;
    logic [31:0] cur_duty;
    logic        mismatch;

    int n_checks = 0;
    int n_pass   = 0;

    pwm_sweep_master_if #(.ADDR_W(ADDR_W)) bus ();

    pwm_sweep_master #(.ADDR_W(ADDR_W), .READ_LATENCY(RL)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .period_val(period_val), .led_mask(led_mask), .duty_max(duty_max),
        .step_interval(step_interval), .bus(bus),
        .busy(busy), .cur_duty(cur_duty), .mismatch(mismatch)
    );

    always #5 clock = ~clock;

    // Slave model: fixed stall per transfer, register echo, fixed read latency,
    // readdata deliberately wrong on every cycle except the valid one.
    int          stall_n  = 0;
    bit          plus_one = 1'b0;
    int          wait_cnt = 0;
    int          rd_age   = 0;
    logic [31:0] rd_val   = '0;
    logic [31:0] mem [4];
    int          cyc      = 0;
    int          stab_err = 0;
    int          both_err = 0;
    logic [7:0]  p_addr   = '0;
    logic        p_rd     = 1'b0;
    logic        p_wr     = 1'b0;
    logic [31:0] p_wd     = '0;
    bit          p_stall  = 1'b0;
    bit          p_rst    = 1'b1;
    txn_t        log_q[$];
    txn_t        exp_q[$];

    assign bus.waitrequest = (bus.read || bus.write) && (wait_cnt < stall_n);
    assign bus.readdata    = (rd_age == RL) ? rd_val : (rd_val ^ 32'h5A5A_0001);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.read && bus.write) both_err <= both_err + 1;
        if (p_stall && !p_rst && (bus.address !== p_addr || bus.read !== p_rd ||
                                  bus.write !== p_wr || bus.writedata !== p_wd))
            stab_err <= stab_err + 1;
        p_addr  <= bus.address;
        p_rd    <= bus.read;
        p_wr    <= bus.write;
        p_wd    <= bus.writedata;
        p_stall <= (bus.read || bus.write) && bus.waitrequest;
        p_rst   <= reset;
        if (reset) begin
            wait_cnt <= 0;
            rd_age   <= 0;
        end else begin
            if (rd_age != 0 && rd_age <= RL) rd_age <= rd_age + 1;
            if (bus.read || bus.write) begin
                if (bus.waitrequest) begin
                    wait_cnt <= wait_cnt + 1;
                end else begin
                    wait_cnt <= 0;
                    log_q.push_back('{wr: bus.write, addr: bus.address, data: bus.writedata, cyc: cyc});
                    if (bus.write) begin
                        mem[bus.address[1:0]] <= bus.writedata;
                    end else begin
                        rd_age <= 1;
                        rd_val <= mem[bus.address[1:0]] + (plus_one ? 32'd1 : 32'd0);
                    end
                end
            end
        end
    end

    // Reference model: the complete transaction list a sweep must produce.
    function automatic void build_exp(input logic [31:0] p, input logic [7:0] m, input logic [31:0] d);
        exp_q.delete();
        exp_q.push_back('{wr: 1'b1, addr: 8'd2, data: p, cyc: 0});
        exp_q.push_back('{wr: 1'b1, addr: 8'd3, data: {24'd0, m}, cyc: 0});
        for (longint k = 0; k <= longint'(d); k++) begin
            exp_q.push_back('{wr: 1'b1, addr: 8'd1, data: 32'(k), cyc: 0});
            if (k == 0) exp_q.push_back('{wr: 1'b1, addr: 8'd0, data: 32'd1, cyc: 0});
            exp_q.push_back('{wr: 1'b0, addr: 8'd1, data: 32'd0, cyc: 0});
        end
        exp_q.push_back('{wr: 1'b1, addr: 8'd0, data: 32'd0, cyc: 0});
    endfunction

    function automatic int first_diff();
        int n = (log_q.size() > exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= log_q.size() || i >= exp_q.size()) return i;
            if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr) return i;
            if (exp_q[i].wr && log_q[i].data !== exp_q[i].data) return i;
        end
        return -1;
    endfunction

    function automatic int count_reads();
        int n = 0;
        foreach (log_q[i]) if (!log_q[i].wr) n++;
        return n;
    endfunction

    function automatic int count_duty_writes();
        int n = 0;
        foreach (log_q[i]) if (log_q[i].wr && log_q[i].addr == 8'd1) n++;
        return n;
    endfunction

    function automatic int duty_time(input logic [31:0] v);
        foreach (log_q[i]) if (log_q[i].wr && log_q[i].addr == 8'd1 && log_q[i].data == v) return log_q[i].cyc;
        return -1000;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] p, input logic [7:0] m, input logic [31:0] d, input logic [31:0] iv);
        log_q.delete();
        period_val = p; led_mask = m; duty_max = d; step_interval = iv;
        start = 1'b1;
        tick();
        start = 1'b0;
        period_val    = $urandom;
        led_mask      = 8'($urandom);
        duty_max      = $urandom_range(5, 9);
        step_interval = $urandom_range(0, 5);
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < MAX_CYC; i++) begin
            if (!busy) begin
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.address !== 8'd0) $display("FAIL reset_address: got %0h want 0", bus.address); else n_pass++;
        n_checks++; if (bus.read !== 1'b0) $display("FAIL reset_read: got %b want 0", bus.read); else n_pass++;
        n_checks++; if (bus.write !== 1'b0) $display("FAIL reset_write: got %b want 0", bus.write); else n_pass++;
        n_checks++; if (bus.writedata !== 32'd0) $display("FAIL reset_writedata: got %0h want 0", bus.writedata); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (cur_duty !== 32'd0) $display("FAIL reset_cur_duty: got %0h want 0", cur_duty); else n_pass++;
        n_checks++; if (mismatch !== 1'b0) $display("FAIL reset_mismatch: got %b want 0", mismatch); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit to;
        int idx, t0, t1, t2;
        stall_n = 0; plus_one = 1'b0;
        build_exp(32'd100, 8'hA5, 32'd2);
        pulse_start(32'd100, 8'hA5, 32'd2, 32'd3);
        n_checks++; if (bus.write !== 1'b1 || bus.address !== 8'd2 || bus.writedata !== 32'd100)
            $display("FAIL basic_start_latency: got wr=%b addr=%0h data=%0h want wr=1 addr=2 data=64", bus.write, bus.address, bus.writedata);
        else n_pass++;
        repeat (4) tick();
        period_val = 32'd55; duty_max = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(to);
        n_checks++; if (to) $display("FAIL basic_timeout: got busy=%b want 0", busy); else n_pass++;
        idx = first_diff();
        n_checks++; if (idx != -1) $display("FAIL basic_sequence: got diff at %0d (%0d txns) want none (%0d txns)", idx, log_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (mismatch !== 1'b0) $display("FAIL basic_mismatch: got %b want 0", mismatch); else n_pass++;
        n_checks++; if (cur_duty !== 32'd2) $display("FAIL basic_cur_duty: got %0h want 2", cur_duty); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", busy); else n_pass++;
        t0 = duty_time(32'd0); t1 = duty_time(32'd1); t2 = duty_time(32'd2);
        n_checks++; if (t1 - t0 != RL + 3 + 3) $display("FAIL basic_first_gap: got %0d want %0d", t1 - t0, RL + 6); else n_pass++;
        n_checks++; if (t2 - t1 != RL + 3 + 2) $display("FAIL basic_hold_gap: got %0d want %0d", t2 - t1, RL + 5); else n_pass++;
    endtask

    task automatic test_stall();
        bit to;
        int idx, s0, b0, t1, t2;
        stall_n = 5; plus_one = 1'b0;
        s0 = stab_err; b0 = both_err;
        build_exp(32'd100, 8'hA5, 32'd2);
        pulse_start(32'd100, 8'hA5, 32'd2, 32'd3);
        wait_idle(to);
        n_checks++; if (to) $display("FAIL stall_timeout: got busy=%b want 0", busy); else n_pass++;
        idx = first_diff();
        n_checks++; if (idx != -1) $display("FAIL stall_sequence: got diff at %0d (%0d txns) want none (%0d txns)", idx, log_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (stab_err - s0 != 0) $display("FAIL stall_stability: got %0d changes want 0", stab_err - s0); else n_pass++;
        n_checks++; if (both_err - b0 != 0) $display("FAIL stall_rd_wr_both: got %0d want 0", both_err - b0); else n_pass++;
        t1 = duty_time(32'd1); t2 = duty_time(32'd2);
        n_checks++; if (t2 - t1 != RL + 3 + 12) $display("FAIL stall_hold_gap: got %0d want %0d", t2 - t1, RL + 15); else n_pass++;
        n_checks++; if (mismatch !== 1'b0) $display("FAIL stall_mismatch: got %b want 0", mismatch); else n_pass++;
        stall_n = 0;
    endtask

    task automatic test_mismatch();
        bit to;
        bit found = 1'b0;
        int idx;
        stall_n = 0; plus_one = 1'b1;
        pulse_start(32'd5, 8'h0F, 32'd1, 32'd1);
        for (int i = 0; i < MAX_CYC; i++) begin
            if (count_reads() > 0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++; if (!found) $display("FAIL mism_no_read: got 0 reads want 1"); else n_pass++;
        repeat (RL - 1) tick();
        n_checks++; if (mismatch !== 1'b0) $display("FAIL mism_early: got %b want 0", mismatch); else n_pass++;
        tick();
        n_checks++; if (mismatch !== 1'b1) $display("FAIL mism_set: got %b want 1", mismatch); else n_pass++;
        wait_idle(to);
        n_checks++; if (to || mismatch !== 1'b1) $display("FAIL mism_sticky: got to=%b mismatch=%b want to=0 mismatch=1", to, mismatch); else n_pass++;
        plus_one = 1'b0;
        build_exp(32'd6, 8'hF0, 32'd1);
        pulse_start(32'd6, 8'hF0, 32'd1, 32'd1);
        n_checks++; if (mismatch !== 1'b0) $display("FAIL mism_clear_on_start: got %b want 0", mismatch); else n_pass++;
        wait_idle(to);
        idx = first_diff();
        n_checks++; if (to || idx != -1 || mismatch !== 1'b0)
            $display("FAIL mism_rerun: got to=%b diff=%0d mismatch=%b want to=0 diff=-1 mismatch=0", to, idx, mismatch);
        else n_pass++;
    endtask

    task automatic test_stop();
        bit to;
        int n;
        stall_n = 0; plus_one = 1'b0;
        pulse_start(32'd200, 8'h3C, 32'd10, 32'd20);
        for (int i = 0; i < MAX_CYC; i++) begin
            if (count_reads() >= 2) break;
            tick();
        end
        repeat (RL + 2) tick();
        n = log_q.size();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(to);
        n_checks++; if (to) $display("FAIL stop_timeout: got busy=%b want 0", busy); else n_pass++;
        n_checks++; if (log_q.size() != n + 1) $display("FAIL stop_txn_count: got %0d want %0d", log_q.size(), n + 1); else n_pass++;
        n_checks++; if (log_q.size() == 0 || !log_q[log_q.size()-1].wr || log_q[log_q.size()-1].addr !== 8'd0 || log_q[log_q.size()-1].data !== 32'd0)
            $display("FAIL stop_disable_write: got last txn not write(0,0), size %0d want write(0,0)", log_q.size());
        else n_pass++;
        n_checks++; if (count_duty_writes() != 2 || cur_duty !== 32'd1)
            $display("FAIL stop_duty: got %0d duty writes cur_duty=%0h want 2 and 1", count_duty_writes(), cur_duty);
        else n_pass++;
    endtask

    task automatic test_stop_stall();
        bit to;
        stall_n = 5; plus_one = 1'b0;
        pulse_start(32'd300, 8'h11, 32'd4, 32'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(to);
        n_checks++; if (to || log_q.size() != 2) $display("FAIL stop_stall_count: got to=%b txns=%0d want to=0 txns=2", to, log_q.size()); else n_pass++;
        n_checks++; if (log_q.size() != 2 || log_q[0].addr !== 8'd2 || log_q[0].data !== 32'd300 ||
                        log_q[1].addr !== 8'd0 || log_q[1].data !== 32'd0 || !log_q[1].wr)
            $display("FAIL stop_stall_seq: got %0d txns want write(2,12c) then write(0,0)", log_q.size());
        else n_pass++;
        stall_n = 0;
    endtask

    task automatic test_reset_mid();
        bit to;
        bit found = 1'b0;
        int idx;
        stall_n = 5; plus_one = 1'b0;
        pulse_start(32'd400, 8'h22, 32'd3, 32'd1);
        for (int i = 0; i < MAX_CYC; i++) begin
            if (bus.write && bus.address == 8'd1 && bus.writedata == 32'd2 && bus.waitrequest) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++; if (!found || cur_duty !== 32'd1) $display("FAIL rstmid_pre: got found=%b cur_duty=%0h want 1 and 1", found, cur_duty); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (bus.write !== 1'b0 || bus.read !== 1'b0) $display("FAIL rstmid_strobes: got wr=%b rd=%b want 0 0", bus.write, bus.read); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (cur_duty !== 32'd0) $display("FAIL rstmid_cur_duty: got %0h want 0", cur_duty); else n_pass++;
        reset = 1'b0;
        stall_n = 0;
        tick();
        build_exp(32'd77, 8'h44, 32'd1);
        pulse_start(32'd77, 8'h44, 32'd1, 32'd2);
        n_checks++; if (bus.write !== 1'b1 || bus.address !== 8'd2 || bus.writedata !== 32'd77)
            $display("FAIL rstmid_restart: got wr=%b addr=%0h data=%0h want 1 2 4d", bus.write, bus.address, bus.writedata);
        else n_pass++;
        wait_idle(to);
        idx = first_diff();
        n_checks++; if (to || idx != -1) $display("FAIL rstmid_sequence: got to=%b diff=%0d want to=0 diff=-1", to, idx); else n_pass++;
    endtask

    task automatic test_random();
        bit to;
        int idx;
        logic [31:0] p, d, iv;
        logic [7:0] m;
        plus_one = 1'b0;
        for (int it = 0; it < 6; it++) begin
            p  = $urandom;
            m  = 8'($urandom_range(0, 255));
            d  = $urandom_range(0, 3);
            iv = $urandom_range(0, 4);
            stall_n = $urandom_range(0, 2);
            stop = 1'b1;
            tick();
            stop = 1'b0;
            build_exp(p, m, d);
            pulse_start(p, m, d, iv);
            wait_idle(to);
            idx = first_diff();
            n_checks++; if (to || idx != -1)
                $display("FAIL random_%0d_sequence: got to=%b diff=%0d (%0d txns) want to=0 diff=-1 (%0d txns)", it, to, idx, log_q.size(), exp_q.size());
            else n_pass++;
            n_checks++; if (cur_duty !== d || mismatch !== 1'b0)
                $display("FAIL random_%0d_final: got cur_duty=%0h mismatch=%b want %0h 0", it, cur_duty, mismatch, d);
            else n_pass++;
        end
        stall_n = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_mismatch();
        test_stop();
        test_stop_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
